// File: rtl/prll_bs_drvr_endpoint.sv
// Driver-slot endpoint for the parallel bus: a show-ahead TX FIFO toward the arbiter and an
// address-filtered show-ahead RX FIFO from the arbiter, both with host-side strobe ports.
module prll_bs_drvr_endpoint #(
  parameter int         bits      = 32,
  parameter int         depth     = 8,
  parameter logic [7:0] id        = 8'h00,
  parameter logic [7:0] broadcast = 8'hFF
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   pndng,
  input  logic                   pop,
  output logic [bits-1:0]        D_pop,
  input  logic                   push,
  input  logic [bits-1:0]        D_push,
  input  logic                   tx_wr,
  input  logic [bits-1:0]        tx_data,
  output logic                   tx_full,
  output logic [$clog2(depth):0] tx_count,
  input  logic                   rx_rd,
  output logic [bits-1:0]        rx_data,
  output logic                   rx_empty,
  output logic [$clog2(depth):0] rx_count,
  output logic                   tx_ovf,
  output logic                   rx_ovf,
  output logic                   rx_drop
);

  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(depth);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [bits-1:0] tx_mem [depth];
  logic [bits-1:0] rx_mem [depth];

  logic [AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic          tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d, rx_drop_q, rx_drop_d;

  logic          tx_do_rd, tx_do_wr, rx_do_rd, rx_do_wr, rx_match;
  logic [7:0]    rx_dest;

  // A read on an empty FIFO never frees a slot, so a full FIFO can only accept with a real read.
  always_comb begin
    rx_dest  = D_push[bits-1 -: 8];
    rx_match = (rx_dest == id) || (rx_dest == broadcast);

    tx_do_rd = pop && (tx_cnt_q != '0);
    tx_do_wr = tx_wr && ((tx_cnt_q < DEPTH_C) || tx_do_rd);
    rx_do_rd = rx_rd && (rx_cnt_q != '0);
    rx_do_wr = push && rx_match && ((rx_cnt_q < DEPTH_C) || rx_do_rd);

    tx_wp_d   = tx_do_wr ? tx_wp_q + PTR_ONE : tx_wp_q;
    tx_rp_d   = tx_do_rd ? tx_rp_q + PTR_ONE : tx_rp_q;
    rx_wp_d   = rx_do_wr ? rx_wp_q + PTR_ONE : rx_wp_q;
    rx_rp_d   = rx_do_rd ? rx_rp_q + PTR_ONE : rx_rp_q;

    tx_cnt_d = tx_cnt_q;
    case ({tx_do_wr, tx_do_rd})
      2'b10:   tx_cnt_d = tx_cnt_q + CNT_ONE;
      2'b01:   tx_cnt_d = tx_cnt_q - CNT_ONE;
      default: tx_cnt_d = tx_cnt_q;
    endcase

    rx_cnt_d = rx_cnt_q;
    case ({rx_do_wr, rx_do_rd})
      2'b10:   rx_cnt_d = rx_cnt_q + CNT_ONE;
      2'b01:   rx_cnt_d = rx_cnt_q - CNT_ONE;
      default: rx_cnt_d = rx_cnt_q;
    endcase

    tx_ovf_d  = tx_ovf_q || (tx_wr && !tx_do_wr);
    rx_ovf_d  = rx_ovf_q || (push && rx_match && !rx_do_wr);
    rx_drop_d = push && !rx_match;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wp_q   <= '0;
      tx_rp_q   <= '0;
      rx_wp_q   <= '0;
      rx_rp_q   <= '0;
      tx_cnt_q  <= '0;
      rx_cnt_q  <= '0;
      tx_ovf_q  <= 1'b0;
      rx_ovf_q  <= 1'b0;
      rx_drop_q <= 1'b0;
    end else begin
      tx_wp_q   <= tx_wp_d;
      tx_rp_q   <= tx_rp_d;
      rx_wp_q   <= rx_wp_d;
      rx_rp_q   <= rx_rp_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_cnt_q  <= rx_cnt_d;
      tx_ovf_q  <= tx_ovf_d;
      rx_ovf_q  <= rx_ovf_d;
      rx_drop_q <= rx_drop_d;
    end
  end

  // Storage carries no reset; validity is tracked entirely by the counts.
  always_ff @(posedge clk) begin
    if (tx_do_wr) tx_mem[tx_wp_q] <= tx_data;
    if (rx_do_wr) rx_mem[rx_wp_q] <= D_push;
  end

  always_comb begin
    pndng    = (tx_cnt_q != '0);
    tx_full  = (tx_cnt_q == DEPTH_C);
    tx_count = tx_cnt_q;
    D_pop    = pndng ? tx_mem[tx_rp_q] : '0;
    rx_empty = (rx_cnt_q == '0);
    rx_count = rx_cnt_q;
    rx_data  = rx_empty ? '0 : rx_mem[rx_rp_q];
    tx_ovf   = tx_ovf_q;
    rx_ovf   = rx_ovf_q;
    rx_drop  = rx_drop_q;
  end

endmodule

// File: tb/tb_prll_bs_drvr_endpoint.sv
// Bench for prll_bs_drvr_endpoint (id=8'h03, depth 8): directed scenarios plus random traffic,
// every cycle compared against a queue-based reference model.
module tb_prll_bs_drvr_endpoint;

  localparam int BITS = 32;
  localparam int DEPTH = 8;
  localparam logic [7:0] MY_ID = 8'h03;

  logic            clk = 1'b0;
  logic            reset;
  logic            pndng, pop, push, tx_wr, tx_full, rx_rd, rx_empty, tx_ovf, rx_ovf, rx_drop;
  logic [BITS-1:0] D_pop, D_push, tx_data, rx_data;
  logic [3:0]      tx_count, rx_count;

  prll_bs_drvr_endpoint #(.bits(BITS), .depth(DEPTH), .id(MY_ID), .broadcast(8'hFF)) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .pop(pop), .D_pop(D_pop),
    .push(push), .D_push(D_push), .tx_wr(tx_wr), .tx_data(tx_data),
    .tx_full(tx_full), .tx_count(tx_count), .rx_rd(rx_rd), .rx_data(rx_data),
    .rx_empty(rx_empty), .rx_count(rx_count), .tx_ovf(tx_ovf), .rx_ovf(rx_ovf),
    .rx_drop(rx_drop)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_tx[$];
  logic [31:0] m_rx[$];
  logic        m_tx_ovf, m_rx_ovf, m_rx_drop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_tx.delete();
    m_rx.delete();
    m_tx_ovf  = 1'b0;
    m_rx_ovf  = 1'b0;
    m_rx_drop = 1'b0;
  endtask

  // One clock edge of endpoint behaviour, decided from the state before the edge.
  task automatic model_edge(input logic tw, input logic [31:0] td, input logic p,
                            input logic ps, input logic [31:0] dp, input logic rr);
    bit tx_take, tx_put, rx_take, rx_put, addr_ok;
    tx_take = p && (m_tx.size() > 0);
    tx_put  = tw && ((m_tx.size() < DEPTH) || tx_take);
    addr_ok = (dp[31:24] == MY_ID) || (dp[31:24] == 8'hFF);
    rx_take = rr && (m_rx.size() > 0);
    rx_put  = ps && addr_ok && ((m_rx.size() < DEPTH) || rx_take);
    if (tx_take) void'(m_tx.pop_front());
    if (tx_put) m_tx.push_back(td);
    if (tw && !tx_put) m_tx_ovf = 1'b1;
    if (rx_take) void'(m_rx.pop_front());
    if (rx_put) m_rx.push_back(dp);
    if (ps && addr_ok && !rx_put) m_rx_ovf = 1'b1;
    m_rx_drop = ps && !addr_ok;
  endtask

  task automatic compare_all();
    chk("pndng",    32'(pndng),    32'(m_tx.size() != 0));
    chk("D_pop",    D_pop,         (m_tx.size() != 0) ? m_tx[0] : 32'h0);
    chk("tx_full",  32'(tx_full),  32'(m_tx.size() == DEPTH));
    chk("tx_count", 32'(tx_count), 32'(m_tx.size()));
    chk("rx_data",  rx_data,       (m_rx.size() != 0) ? m_rx[0] : 32'h0);
    chk("rx_empty", 32'(rx_empty), 32'(m_rx.size() == 0));
    chk("rx_count", 32'(rx_count), 32'(m_rx.size()));
    chk("tx_ovf",   32'(tx_ovf),   32'(m_tx_ovf));
    chk("rx_ovf",   32'(rx_ovf),   32'(m_rx_ovf));
    chk("rx_drop",  32'(rx_drop),  32'(m_rx_drop));
  endtask

  // Apply inputs for one cycle, advance the model at the edge, then compare 1 time unit later.
  task automatic step(input logic tw, input logic [31:0] td, input logic p,
                      input logic ps, input logic [31:0] dp, input logic rr);
    tx_wr = tw; tx_data = td; pop = p; push = ps; D_push = dp; rx_rd = rr;
    @(posedge clk);
    model_edge(tw, td, p, ps, dp, rr);
    #1;
    tx_wr = 1'b0; pop = 1'b0; push = 1'b0; rx_rd = 1'b0;
    compare_all();
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    logic [31:0] w;
    logic [7:0]  dest;
    reset = 1'b1;
    tx_wr = 1'b0; tx_data = '0; pop = 1'b0; push = 1'b0; D_push = '0; rx_rd = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    chk("rst_pndng", 32'(pndng), 32'h0);
    chk("rst_rx_empty", 32'(rx_empty), 32'h1);
    reset = 1'b0;

    // First write shows up one cycle later.
    step(1'b1, 32'h0000_0011, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("first_D_pop", D_pop, 32'h0000_0011);
    chk("first_count", 32'(tx_count), 32'h1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);

    // Fill past full, then drain in order across the pointer wrap.
    for (int i = 1; i <= 9; i++) begin
      step(1'b1, 32'(i), 1'b0, 1'b0, 32'h0, 1'b0);
      if (i == 8) chk("full_after_8", 32'(tx_full), 32'h1);
    end
    chk("tx_ovf_9th", 32'(tx_ovf), 32'h1);
    for (int i = 1; i <= 8; i++) begin
      chk("drain_order", D_pop, 32'(i));
      step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    end
    chk("drained_D_pop", D_pop, 32'h0);

    // Address filter.
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'h03AA_AAAA, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'hFFBB_BBBB, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'h05CC_CCCC, 1'b0);
    chk("drop_pulse", 32'(rx_drop), 32'h1);
    chk("rx_count_2", 32'(rx_count), 32'h2);
    idle();
    chk("drop_cleared", 32'(rx_drop), 32'h0);
    chk("rx_head0", rx_data, 32'h03AA_AAAA);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("rx_head1", rx_data, 32'hFFBB_BBBB);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);

    // RX full behaviour.
    for (int i = 0; i < DEPTH; i++) step(1'b0, 32'h0, 1'b0, 1'b1, 32'h0300_0100 + 32'(i), 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'h0300_0200, 1'b1);
    chk("rx_full_rd_count", 32'(rx_count), 32'h8);
    chk("rx_full_rd_ovf", 32'(rx_ovf), 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'hFF00_0300, 1'b0);
    chk("rx_ovf_set", 32'(rx_ovf), 32'h1);
    chk("rx_head_kept", rx_data, 32'h0300_0101);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);

    // Reads on empty FIFOs, then write+pop on empty TX.
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 32'hDEAD_0001, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("wr_pop_empty", 32'(tx_count), 32'h1);

    // Half-fill both, then reset asynchronously between edges.
    for (int i = 0; i < 4; i++)
      step(1'b1, 32'hA000_0000 + 32'(i), 1'b0, 1'b1, 32'h03B0_0000 + 32'(i), 1'b0);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    compare_all();
    chk("async_D_pop", D_pop, 32'h0);
    @(posedge clk);
    #1;
    compare_all();
    reset = 1'b0;
    step(1'b1, 32'h0000_0055, 1'b0, 1'b1, 32'h0300_0055, 1'b0);
    chk("post_rst_tx", D_pop, 32'h0000_0055);
    chk("post_rst_rx", rx_data, 32'h0300_0055);

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      case ($urandom_range(0, 2))
        0: dest = MY_ID;
        1: dest = 8'hFF;
        default: dest = 8'($urandom);
      endcase
      w = {dest, 24'($urandom)};
      step(1'($urandom_range(0, 9) < 6), $urandom, 1'($urandom_range(0, 9) < 4),
           1'($urandom_range(0, 9) < 6), w, 1'($urandom_range(0, 9) < 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
